// File: rtl/sprite_line_engine.sv
`default_nettype none
// ============================================================================
// Module   : sprite_line_engine
// Purpose  : Scanline sprite renderer into a double line buffer. Define
//            SPRITE_FLIP_EN to honour the per-sprite hflip/vflip flag bits.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_line_engine #(
    parameter int NUM_SPRITES  = 8,
    parameter int SPR_SIZE     = 16,
    parameter int SCRN_ROWS    = 288,
    parameter int SCRN_COLS    = 224,
    parameter int MAX_PER_LINE = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [8:0]                          row,
    input  logic [9:0]                          col,
    input  logic                                blank,
    input  logic                                wr_en,
    input  logic [$clog2(NUM_SPRITES*4)-1:0]    RAM_addr,
    input  logic [7:0]                          sprite_RAM_din,
    output logic [8+2*$clog2(SPR_SIZE)-1:0]     pix_addr,
    input  logic [11:0]                         pix_data,
    output logic                                busy,
    output logic                                line_overflow,
    output logic                                render_late,
    output logic [3:0]                          sprite_r,
    output logic [3:0]                          sprite_g,
    output logic [3:0]                          sprite_b
);

    localparam int c_AW    = $clog2(NUM_SPRITES*4);
    localparam int c_IDX_W = c_AW - 2;
    localparam int c_L     = $clog2(SPR_SIZE);
    localparam int c_COL_W = $clog2(SCRN_COLS);
    localparam int c_HIT_W = $clog2(MAX_PER_LINE+1);
    localparam int c_CNT_W = $clog2(SCRN_COLS + SPR_SIZE + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SCAN  = 2'd2,
        ST_FETCH = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [7:0]           r_attr [NUM_SPRITES*4];
    logic [11:0]          r_buf0 [SCRN_COLS];
    logic [11:0]          r_buf1 [SCRN_COLS];

    logic [8:0]           r_row_prev;
    logic [8:0]           r_t;
    logic                 r_front;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_HIT_W-1:0]   r_hits;
    logic [7:0]           r_x;
    logic [7:0]           r_code;
    logic [c_L-1:0]       r_line;
    logic                 r_hflip;
    logic                 r_a_vld;
    logic                 r_d_vld;
    logic [9:0]           r_a_col;
    logic [9:0]           r_d_col;

    logic                 w_row_chg;
    logic [7:0]           w_y;
    logic [7:0]           w_x;
    logic [7:0]           w_code;
    logic [8:0]           w_dy;
    logic                 w_t_vis;
    logic                 w_hit;
    logic                 w_last_idx;
    logic                 w_hits_full;
    logic                 w_clear_done;
    logic                 w_fetch_done;
    logic                 w_hflip_scan;
    logic                 w_vflip_scan;
    logic [c_L-1:0]       w_line_scan;
    logic [c_L-1:0]       w_fetch_pix;
    logic [11:0]          w_back_rd;
    logic                 w_pix_we;
    logic                 w_clr_we;
    logic                 w_buf_we;
    logic [c_COL_W-1:0]   w_buf_waddr;
    logic [11:0]          w_buf_wdata;
    logic [c_COL_W-1:0]   w_col_idx;
    logic                 w_pix_vis;

    assign w_row_chg    = (row != r_row_prev);
    assign busy         = (r_state != ST_IDLE);

    assign w_y          = r_attr[{r_idx, 2'd0}];
    assign w_x          = r_attr[{r_idx, 2'd1}];
    assign w_code       = r_attr[{r_idx, 2'd2}];
    // Wraps modulo 512 so sprites partly above the top edge still hit.
    assign w_dy         = r_t - {1'b0, w_y};
    assign w_t_vis      = (r_t < 9'(SCRN_ROWS));
    assign w_hit        = w_t_vis && (w_dy < 9'(SPR_SIZE));
    assign w_last_idx   = (r_idx == c_IDX_W'(NUM_SPRITES-1));
    assign w_hits_full  = (r_hits == c_HIT_W'(MAX_PER_LINE));
    assign w_clear_done = (r_cnt == c_CNT_W'(SCRN_COLS-1));
    assign w_fetch_done = (r_cnt == c_CNT_W'(SPR_SIZE));

`ifdef SPRITE_FLIP_EN
    assign w_hflip_scan = r_attr[{r_idx, 2'd3}][0];
    assign w_vflip_scan = r_attr[{r_idx, 2'd3}][1];
`else
    assign w_hflip_scan = 1'b0;
    assign w_vflip_scan = 1'b0;
`endif

    assign w_line_scan  = w_vflip_scan ? ~w_dy[c_L-1:0] : w_dy[c_L-1:0];
    assign w_fetch_pix  = r_hflip ? ~r_cnt[c_L-1:0] : r_cnt[c_L-1:0];

    // Back buffer is buf1 when front select is 0; pixels only land on clear entries.
    assign w_back_rd    = r_front ? r_buf0[r_d_col[c_COL_W-1:0]] : r_buf1[r_d_col[c_COL_W-1:0]];
    assign w_pix_we     = r_d_vld && (pix_data != 12'h000) &&
                          (r_d_col < 10'(SCRN_COLS)) && (w_back_rd == 12'h000);
    assign w_clr_we     = (r_state == ST_CLEAR) && !w_row_chg;
    assign w_buf_we     = !rst && (w_clr_we || w_pix_we);
    assign w_buf_waddr  = w_clr_we ? r_cnt[c_COL_W-1:0] : r_d_col[c_COL_W-1:0];
    assign w_buf_wdata  = w_clr_we ? 12'h000 : pix_data;

    assign w_col_idx    = col[c_COL_W-1:0];
    assign w_pix_vis    = !blank && (row < 9'(SCRN_ROWS)) && (col < 10'(SCRN_COLS));

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_attr[RAM_addr] <= sprite_RAM_din;
        end
    end

    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            if (r_front) begin
                r_buf0[w_buf_waddr] <= w_buf_wdata;
            end else begin
                r_buf1[w_buf_waddr] <= w_buf_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_row_chg) begin
            w_state_nxt = ST_CLEAR;
        end else begin
            case (r_state)
                ST_IDLE:  w_state_nxt = ST_IDLE;
                ST_CLEAR: begin
                    if (w_clear_done) begin
                        w_state_nxt = w_t_vis ? ST_SCAN : ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    if (w_hit && !w_hits_full) begin
                        w_state_nxt = ST_FETCH;
                    end else if (w_last_idx) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    if (w_fetch_done) begin
                        w_state_nxt = w_last_idx ? ST_IDLE : ST_SCAN;
                    end
                end
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_prev    <= 9'd0;
            r_front       <= 1'b0;
            r_t           <= 9'd0;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_hits        <= '0;
            r_x           <= 8'd0;
            r_code        <= 8'd0;
            r_line        <= '0;
            r_hflip       <= 1'b0;
            r_a_vld       <= 1'b0;
            r_d_vld       <= 1'b0;
            r_a_col       <= 10'd0;
            r_d_col       <= 10'd0;
            pix_addr      <= '0;
            line_overflow <= 1'b0;
            render_late   <= 1'b0;
            sprite_r      <= 4'd0;
            sprite_g      <= 4'd0;
            sprite_b      <= 4'd0;
        end else begin
            r_row_prev <= row;
            r_a_vld    <= 1'b0;
            r_d_vld    <= r_a_vld;
            r_d_col    <= r_a_col;

            if (w_row_chg) begin
                r_front <= ~r_front;
                r_t     <= row + 9'd1;
                r_cnt   <= '0;
                r_d_vld <= 1'b0;
                if (busy) begin
                    render_late <= 1'b1;
                end
            end else begin
                case (r_state)
                    ST_CLEAR: begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_clear_done) begin
                            r_idx  <= '0;
                            r_hits <= '0;
                        end
                    end
                    ST_SCAN: begin
                        if (w_hit && !w_hits_full) begin
                            r_x      <= w_x;
                            r_code   <= w_code;
                            r_line   <= w_line_scan;
                            r_hflip  <= w_hflip_scan;
                            r_hits   <= r_hits + 1'b1;
                            r_cnt    <= c_CNT_W'(1);
                            pix_addr <= {w_code, w_line_scan, {c_L{w_hflip_scan}}};
                            r_a_vld  <= 1'b1;
                            r_a_col  <= {2'b00, w_x};
                        end else begin
                            if (w_hit) begin
                                line_overflow <= 1'b1;
                            end
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                    ST_FETCH: begin
                        if (w_fetch_done) begin
                            r_idx <= r_idx + 1'b1;
                        end else begin
                            pix_addr <= {r_code, r_line, w_fetch_pix};
                            r_a_vld  <= 1'b1;
                            r_a_col  <= {2'b00, r_x} + 10'(r_cnt);
                            r_cnt    <= r_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            if (w_pix_vis) begin
                {sprite_r, sprite_g, sprite_b} <= r_front ? r_buf1[w_col_idx] : r_buf0[w_col_idx];
            end else begin
                {sprite_r, sprite_g, sprite_b} <= 12'h000;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sprite_line_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_line_engine
// Purpose  : Self-checking bench for sprite_line_engine with a line-level
//            reference renderer and a behavioural sprite ROM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_line_engine;

    localparam int NS   = 16;
    localparam int SS   = 16;
    localparam int ROWS = 288;
    localparam int COLS = 224;
    localparam int MAXL = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  row;
    logic [9:0]  col;
    logic        blank;
    logic        wr_en;
    logic [5:0]  RAM_addr;
    logic [7:0]  sprite_RAM_din;
    logic [15:0] pix_addr;
    logic [11:0] pix_data;
    logic        busy;
    logic        line_overflow;
    logic        render_late;
    logic [3:0]  sprite_r;
    logic [3:0]  sprite_g;
    logic [3:0]  sprite_b;

    sprite_line_engine #(
        .NUM_SPRITES  (NS),
        .SPR_SIZE     (SS),
        .SCRN_ROWS    (ROWS),
        .SCRN_COLS    (COLS),
        .MAX_PER_LINE (MAXL)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .row            (row),
        .col            (col),
        .blank          (blank),
        .wr_en          (wr_en),
        .RAM_addr       (RAM_addr),
        .sprite_RAM_din (sprite_RAM_din),
        .pix_addr       (pix_addr),
        .pix_data       (pix_data),
        .busy           (busy),
        .line_overflow  (line_overflow),
        .render_late    (render_late),
        .sprite_r       (sprite_r),
        .sprite_g       (sprite_g),
        .sprite_b       (sprite_b)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          sy [NS];
    int          sx [NS];
    int          scode [NS];
    int          sflags [NS];
    logic [11:0] exp_line [COLS];
    bit          exp_ovf = 1'b0;
    bit          exp_late = 1'b0;

    // Sprite ROM: codes 1..4 are fixed patterns, the rest a transparent-holed hash.
    function automatic logic [11:0] rom_fn(input logic [15:0] a);
        int code, ln, px;
        code = int'(a[15:8]);
        ln   = int'(a[7:4]);
        px   = int'(a[3:0]);
        case (code)
            1:       return 12'hF00;
            2:       return 12'h0F0;
            3:       return 12'h00F;
            4:       return (px == 0) ? 12'hF00 : 12'h000;
            default: begin
                if ((code + ln + px) % 5 == 0) return 12'h000;
                return 12'((code*37 + ln*11 + px*5) % 4095 + 1);
            end
        endcase
    endfunction

    always @(posedge clk) pix_data <= rom_fn(pix_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_line(input int t, output bit ovf);
        int hits, dy, px, ln, cc;
        logic [11:0] pv;
        logic [15:0] a;
        hits = 0;
        ovf  = 1'b0;
        for (int c = 0; c < COLS; c++) exp_line[c] = 12'h000;
        if (t < ROWS) begin
            for (int s = 0; s < NS; s++) begin
                dy = ((t - sy[s]) % 512 + 512) % 512;
                if (dy < SS) begin
                    hits++;
                    if (hits > MAXL) begin
                        ovf = 1'b1;
                    end else begin
                        for (int i = 0; i < SS; i++) begin
                            px = i;
                            ln = dy;
`ifdef SPRITE_FLIP_EN
                            if ((sflags[s] & 1) != 0) px = SS - 1 - i;
                            if ((sflags[s] & 2) != 0) ln = SS - 1 - dy;
`endif
                            a  = 16'(scode[s]*256 + ln*16 + px);
                            pv = rom_fn(a);
                            cc = sx[s] + i;
                            if (pv != 12'h000 && cc < COLS && exp_line[cc] == 12'h000)
                                exp_line[cc] = pv;
                        end
                    end
                end
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic wr_byte(input int a, input int d);
        RAM_addr       = 6'(a);
        sprite_RAM_din = 8'(d);
        wr_en          = 1'b1;
        tick();
        wr_en          = 1'b0;
    endtask

    task automatic set_sprite(input int s, input int y, input int x, input int code, input int fl);
        wait_idle();
        wr_byte(s*4 + 0, y);
        wr_byte(s*4 + 1, x);
        wr_byte(s*4 + 2, code);
        wr_byte(s*4 + 3, fl);
        sy[s] = y; sx[s] = x; scode[s] = code; sflags[s] = fl;
    endtask

    task automatic park_all();
        for (int s = 0; s < NS; s++) set_sprite(s, 255, 0, 5, 0);
    endtask

    task automatic row_change(input int newrow);
        bit o;
        model_line((newrow + 1) % 512, o);
        exp_ovf = exp_ovf | o;
        row = 9'(newrow);
        tick();
    endtask

    task automatic show_line(input int t);
        bit o;
        wait_idle();
        if (row == 9'(t - 1)) begin
            row_change(t + 100);
            wait_idle();
        end
        row_change(t - 1);
        wait_idle();
        col = 10'd0;
        row_change(t);
        model_line(t, o);
        for (int c = 0; c < COLS; c++) begin
            col = 10'(c);
            tick();
            check($sformatf("L%0d_c%0d", t, c), 32'({sprite_r, sprite_g, sprite_b}), 32'(exp_line[c]));
        end
        wait_idle();
        check($sformatf("ovf_after_L%0d", t), 32'(line_overflow), 32'(exp_ovf));
    endtask

    initial begin
        rst = 1'b1; row = 9'd0; col = 10'd0; blank = 1'b0;
        wr_en = 1'b0; RAM_addr = 6'd0; sprite_RAM_din = 8'd0;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(line_overflow), 32'd0);
        check("rst_late", 32'(render_late), 32'd0);
        check("rst_pix_addr", 32'(pix_addr), 32'd0);
        check("rst_rgb", 32'({sprite_r, sprite_g, sprite_b}), 32'd0);
        rst = 1'b0;
        tick();
        park_all();

        // Single red sprite, then blanking and off-screen column.
        set_sprite(0, 10, 20, 1, 0);
        show_line(10);
        col = 10'd25; tick();
        check("red_c25", 32'({sprite_r, sprite_g, sprite_b}), 32'h F00);
        blank = 1'b1; tick();
        check("blank_zero", 32'({sprite_r, sprite_g, sprite_b}), 32'd0);
        blank = 1'b0; col = 10'd230; tick();
        check("col_oob_zero", 32'({sprite_r, sprite_g, sprite_b}), 32'd0);

        // Overlap priority.
        set_sprite(0, 40, 50, 2, 0);
        set_sprite(1, 40, 50, 3, 0);
        show_line(40);

        // Right-edge clipping.
        set_sprite(0, 120, 216, 1, 0);
        set_sprite(1, 255, 0, 5, 0);
        show_line(120);
        show_line(135);

        // Off-screen target: CLEAR only, then idle.
        wait_idle();
        row_change(299);
        check("oob_busy_start", 32'(busy), 32'd1);
        repeat (COLS - 1) tick();
        check("oob_clear_len", 32'(busy), 32'd1);
        tick();
        check("oob_idle", 32'(busy), 32'd0);
        col = 10'd10; tick();
        check("row_oob_zero", 32'({sprite_r, sprite_g, sprite_b}), 32'd0);

        // Row change while busy, then reset in the middle of a fetch.
        set_sprite(0, 60, 10, 1, 0);
        wait_idle();
        row_change(59);
        repeat (3) tick();
        row_change(60);
        exp_late = 1'b1;
        check("render_late_set", 32'(render_late), 32'(exp_late));
        check("late_restart_busy", 32'(busy), 32'd1);
        repeat (COLS + 4) tick();
        check("mid_fetch_busy", 32'(busy), 32'd1);
        check("mid_fetch_code", 32'(pix_addr[15:8]), 32'd1);
        rst = 1'b1; row = 9'd0; tick();
        exp_ovf = 1'b0; exp_late = 1'b0;
        check("rst_abort_busy", 32'(busy), 32'd0);
        check("rst_abort_pix", 32'(pix_addr), 32'd0);
        check("rst_abort_late", 32'(render_late), 32'(exp_late));
        rst = 1'b0; tick();
        park_all();

        // Nine sprites on one line.
        for (int s = 0; s < 9; s++) set_sprite(s, 100, s*25, int'($urandom_range(5, 255)), 0);
        show_line(100);
        check("overflow_sticky", 32'(line_overflow), 32'd1);

        // Randomised scenes near the chosen line.
        for (int it = 0; it < 6; it++) begin
            int t;
            t = int'($urandom_range(1, ROWS - 1));
            for (int s = 0; s < NS; s++)
                set_sprite(s, (t - int'($urandom_range(0, 20))) & 255, int'($urandom_range(0, 255)),
                           int'($urandom_range(1, 255)), int'($urandom_range(0, 3)));
            show_line(t);
        end

`ifdef SPRITE_FLIP_EN
        park_all();
        set_sprite(0, 150, 30, 4, 1);
        show_line(150);
`endif

        check("late_final", 32'(render_late), 32'(exp_late));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sprite_line_engine.md
SPRITE_LINE_ENGINE -- requirements
Module: sprite_line_engine

Interface
REQ-001 SHALL have parameter NUM_SPRITES, default 8: number of sprite attribute slots, power of 2.
REQ-002 SHALL have parameter SPR_SIZE, default 16: sprite width and height in pixels, power of 2.
REQ-003 SHALL have parameter SCRN_ROWS, default 288: visible rows.
REQ-004 SHALL have parameter SCRN_COLS, default 224: visible columns.
REQ-005 SHALL have parameter MAX_PER_LINE, default 8: sprites drawn per line, at most NUM_SPRITES.
REQ-006 SHALL have ports, in this order:
- clk  in  1  system clock; one clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- row  in  9  VGA row.
- col  in  10  VGA column.
- blank  in  1  VGA blanking.
- wr_en  in  1  attribute write strobe.
- RAM_addr  in  log2(NUM_SPRITES*4)  attribute byte address.
- sprite_RAM_din  in  8  attribute write data.
- pix_addr  out  8+2*log2(SPR_SIZE)  sprite ROM address {code, line, pixel}.
- pix_data  in  12  sprite ROM RGB, valid one cycle after pix_addr; 12'h000 is transparent.
- busy  out  1  render FSM not IDLE.
- line_overflow  out  1  sticky; a line had more than MAX_PER_LINE hits.
- render_late  out  1  sticky; a row change arrived while busy.
- sprite_r, sprite_g, sprite_b  out  4 each  pixel colour.

Function
REQ-007 SHALL store 4 bytes per sprite: byte0 Y, byte1 X, byte2 code, byte3 flags; a write takes effect on the next clock.
REQ-008 SHALL hold two line buffers of SCRN_COLS x 12 bits: front is displayed, back is rendered.
REQ-009 SHALL detect a row change when row differs from its value on the previous clock; on that clock, swap front and back and start rendering target line T = row+1.
REQ-010 SHALL sequence the FSM IDLE -> CLEAR -> SCAN -> FETCH -> (SCAN | IDLE).
REQ-011 CLEAR SHALL write 12'h000 to every back-buffer entry, one per cycle, for SCRN_COLS cycles.
REQ-012 SCAN SHALL test one sprite per cycle, index 0 upward; hit when (T - Y) mod 512 < SPR_SIZE, computed in 9 bits.
REQ-013 If T >= SCRN_ROWS, SCAN SHALL find no hits and return the FSM to IDLE after CLEAR.
REQ-014 On a hit, FETCH SHALL issue SPR_SIZE consecutive pix_addr values, pixel index i = 0..SPR_SIZE-1, line = T - Y.
REQ-015 SHALL write each returned pixel one cycle after its address, to back-buffer column X+i, only if pix_data != 0, X+i < SCRN_COLS, and the entry is still 12'h000.
- Result: the lower sprite index wins overlaps.
REQ-016 After FETCH, SHALL resume SCAN at the next index; after the last index, go to IDLE.
REQ-017 SHALL stop fetching after MAX_PER_LINE hits; a further hit SHALL set line_overflow and be ignored.
REQ-018 A row change while busy SHALL set render_late, swap buffers (partial line shown), and restart at CLEAR for the new T.
REQ-019 Output SHALL be registered, latency 1: the colour is the front-buffer entry [col], or 0 when blank, row >= SCRN_ROWS, or col >= SCRN_COLS.
REQ-020 Worst-case render time, SCRN_COLS + NUM_SPRITES + MAX_PER_LINE*(SPR_SIZE+1) cycles, SHALL fit within one line period; this is the integrator's obligation.

Reset
REQ-021 Reset SHALL set: FSM to IDLE; busy, line_overflow, render_late to 0; sprite_r/g/b to 0; pix_addr to 0; front-buffer select to 0; row-history register to 0.
REQ-022 Reset SHALL leave attribute and line-buffer contents undefined; software rewrites attributes, and the first render clears the back buffer.
REQ-023 Reset mid-render SHALL abort with no further buffer writes.

Configuration
REQ-024 With SPRITE_FLIP_EN defined, flags bit0 = hflip and bit1 = vflip: hflip uses pixel index SPR_SIZE-1-i while still writing column X+i; vflip uses line SPR_SIZE-1-(T-Y).
REQ-025 Without SPRITE_FLIP_EN, the flags byte SHALL be stored but ignored.

Verification
REQ-026 Sprite 0 at Y=10, X=20, ROM all 12'hF00; row steps 9->10 -> row 10, cols 20..35 output r=F, g=0, b=0 one cycle after col; other columns 0.
REQ-027 Sprites 0 and 1 both at X=50, Y=40; ROM 12'h0F0 for sprite 0, 12'h00F for sprite 1 -> row 40 cols 50..65 green.
REQ-028 Nine sprites on Y=100 with MAX_PER_LINE=8 -> sprites 0..7 drawn, sprite 8 absent, line_overflow=1 until rst.
REQ-029 Sprite at X=216 -> cols 216..223 drawn, no write beyond col 223; blank=1 -> output 0.
REQ-030 Row change with busy=1 -> render_late=1 and the FSM re-enters CLEAR next cycle; rst mid-FETCH -> busy=0 next cycle.
REQ-031 SPRITE_FLIP_EN defined, flags=01, ROM pixel 0 red, others transparent -> red appears at column X+15 only.
